// File: rtl/frame_load_ctrl.sv
// frame_load_ctrl
// Sequencing controller for the 2500-bit obstacle-image assembler.
// Clears the assembler, gates WORDS stream words into it with a
// backpressured handshake, holds the finished frame while the lattice
// is in its collision phase, then presents it to the solver with a
// ready/ack handshake.
//
// Build option: define FRAME_TIMEOUT_EN to add a load-stall watchdog.
// When the watchdog fires, err_timeout is set and the load is dropped.
// Without the macro, LOAD waits indefinitely and err_timeout stays 0.

module frame_load_ctrl #(
  parameter int TOTAL_BITS     = 2500,
  parameter int WORD_W         = 32,
  parameter int WORDS          = (TOTAL_BITS + WORD_W - 1) / WORD_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  input  logic              in_collision_state,
  output logic              asm_clear,
  output logic              asm_word_valid,
  output logic [WORD_W-1:0] asm_word,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_PRESENT = 3'd4
  } state_t;

  localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);

  state_t              state_r;
  logic [6:0]          word_cnt_r;
  logic                asm_clear_r;
  logic                asm_word_valid_r;
  logic [WORD_W-1:0]   asm_word_r;
  logic                frame_ready_r;
  logic                busy_r;
  logic [15:0]         frame_count_r;
  logic                err_timeout_r;
  logic                xfer_s;
  logic                stall_hit_s;

  // Ready depends on state alone so the upstream source never sees a
  // combinational path from its own valid back to ready.
  assign s_ready = (state_r == ST_LOAD);
  assign xfer_s  = s_valid && (state_r == ST_LOAD);

`ifdef FRAME_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt_r;

  // The watchdog fires on the cycle that would take the idle count to TIMEOUT_CYCLES.
  assign stall_hit_s = (state_r == ST_LOAD) && !xfer_s && (stall_cnt_r == STALL_LAST);

  // Stall counter: counts idle LOAD cycles, restarts on every transfer and outside LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r != ST_LOAD) || xfer_s || abort) begin
      stall_cnt_r <= 16'd0;
    end else begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end
`else
  assign stall_hit_s = 1'b0;
`endif

  // Main sequencer: state transitions and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      word_cnt_r       <= 7'd0;
      asm_clear_r      <= 1'b0;
      asm_word_valid_r <= 1'b0;
      asm_word_r       <= '0;
      frame_ready_r    <= 1'b0;
      busy_r           <= 1'b0;
      frame_count_r    <= 16'd0;
      err_timeout_r    <= 1'b0;
    end else begin
      // Clear and word strobes are single-cycle pulses unless re-armed below.
      asm_clear_r      <= 1'b0;
      asm_word_valid_r <= 1'b0;

      if (abort) begin
        // Abort wins over everything; the partial frame is simply dropped.
        state_r       <= ST_IDLE;
        frame_ready_r <= 1'b0;
        busy_r        <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              state_r       <= ST_CLEAR;
              asm_clear_r   <= 1'b1;
              busy_r        <= 1'b1;
              err_timeout_r <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
            end
          end

          ST_CLEAR: begin
            word_cnt_r    <= 7'd0;
            err_timeout_r <= 1'b0;
            state_r       <= ST_LOAD;
          end

          ST_LOAD: begin
            if (xfer_s) begin
              asm_word_r       <= s_data;
              asm_word_valid_r <= 1'b1;
              word_cnt_r       <= word_cnt_r + 7'd1;
              if (word_cnt_r == LAST_WORD) begin
                state_r <= ST_HOLD;
              end else begin
                state_r <= ST_LOAD;
              end
            end else if (stall_hit_s) begin
              err_timeout_r <= 1'b1;
              busy_r        <= 1'b0;
              state_r       <= ST_IDLE;
            end else begin
              state_r <= ST_LOAD;
            end
          end

          ST_HOLD: begin
            // The solver must be out of its collision phase before handoff.
            if (!in_collision_state) begin
              frame_ready_r <= 1'b1;
              state_r       <= ST_PRESENT;
            end else begin
              state_r <= ST_HOLD;
            end
          end

          ST_PRESENT: begin
            // Once presented, the frame stays offered regardless of collision phase.
            if (frame_ack) begin
              frame_ready_r <= 1'b0;
              frame_count_r <= frame_count_r + 16'd1;
              busy_r        <= 1'b0;
              state_r       <= ST_IDLE;
            end else begin
              state_r <= ST_PRESENT;
            end
          end

          default: begin
            frame_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign asm_clear      = asm_clear_r;
  assign asm_word_valid = asm_word_valid_r;
  assign asm_word       = asm_word_r;
  assign frame_ready    = frame_ready_r;
  assign busy           = busy_r;
  assign frame_count    = frame_count_r;
  assign err_timeout    = err_timeout_r;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Self-checking bench for frame_load_ctrl. Accepted stream words are pushed
// to a scoreboard queue and popped against each assembler word strobe.

module tb_frame_load_ctrl;

  localparam int WORD_W = 32;
  localparam int WORDS  = 79;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;
  logic              in_collision_state;
  logic              asm_clear;
  logic              asm_word_valid;
  logic [WORD_W-1:0] asm_word;
  logic              frame_ready;
  logic              frame_ack;
  logic              busy;
  logic [15:0]       frame_count;
  logic              err_timeout;

  int checks;
  int failures;
  int xfer_cnt;
  int edges;
  int exp_count;
  logic [31:0] seq_d;
  logic [31:0] exp_q[$];

  frame_load_ctrl #(
    .TOTAL_BITS(2500),
    .WORD_W(WORD_W),
    .WORDS(WORDS),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .in_collision_state(in_collision_state),
    .asm_clear(asm_clear),
    .asm_word_valid(asm_word_valid),
    .asm_word(asm_word),
    .frame_ready(frame_ready),
    .frame_ack(frame_ack),
    .busy(busy),
    .frame_count(frame_count),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare assembler strobes, then record words accepted at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (asm_word_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_strobe", asm_word_valid, 1'b0);
        else chk("sb_word", asm_word, exp_q.pop_front());
      end
      if (s_valid && s_ready && !abort) begin
        exp_q.push_back(s_data);
        xfer_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic start_frame();
    xfer_cnt = 0;
    edges    = 0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    chk("clr_pulse", asm_clear, 1'b1);
    chk("clr_busy", busy, 1'b1);
    chk("clr_sready", s_ready, 1'b0);
  endtask

  // Feed cnt accepted words; seq selects incrementing data from seq_d, else random.
  task automatic feed(input int cnt, input bit gaps, input bit seq);
    int n;
    int guard;
    bit xf;
    n = 0;
    guard = 0;
    while (n < cnt && guard < 2000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = seq ? seq_d : $urandom;
      xf = s_valid && s_ready;
      step();
      guard++;
      if (xf) begin
        n++;
        seq_d = seq_d + 32'd1;
      end
    end
    chk("feed_count", n, cnt);
  endtask

  // After the last word: verify HOLD behaviour and the rise of frame_ready.
  task automatic finish_frame(input bit coll, input bit timing);
    if (timing) chk("load_edges", edges, 81);
    chk("last_strobe", asm_word_valid, 1'b1);
    chk("last_word", asm_word, s_data);
    chk("hold_sready", s_ready, 1'b0);
    chk("hold_fr", frame_ready, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'hBAD0_0000;
    if (coll) begin
      for (int k = 0; k < 20; k++) begin
        step();
        chk("coll_hold_fr", frame_ready, 1'b0);
      end
      in_collision_state = 1'b0;
      step();
      chk("coll_release_fr", frame_ready, 1'b1);
    end else begin
      step();
      chk("fr_rise", frame_ready, 1'b1);
      if (timing) chk("fr_edge", edges, 82);
    end
    s_valid = 1'b0;
    chk("xfer_total", xfer_cnt, WORDS);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  // Ack the frame; start in the ack cycle must be ignored.
  task automatic ack_frame();
    in_collision_state = 1'b1;
    step();
    step();
    chk("present_keep", frame_ready, 1'b1);
    in_collision_state = 1'b0;
    frame_ack = 1'b1;
    start     = 1'b1;
    step();
    frame_ack = 1'b0;
    start     = 1'b0;
    exp_count++;
    chk("ack_fr", frame_ready, 1'b0);
    chk("ack_busy", busy, 1'b0);
    chk("ack_count", frame_count, exp_count);
    chk("ack_no_clear", asm_clear, 1'b0);
    step();
    chk("ack_start_ignored", busy, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    xfer_cnt = 0;
    edges = 0;
    exp_count = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    in_collision_state = 1'b0;
    frame_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sready", s_ready, 1'b0);
    chk("rst_clear", asm_clear, 1'b0);
    chk("rst_wvalid", asm_word_valid, 1'b0);
    chk("rst_word", asm_word, 32'd0);
    chk("rst_fr", frame_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", frame_count, 16'd0);
    chk("rst_err", err_timeout, 1'b0);
    rst_n = 1'b1;
    step();

    // Back-to-back sequential frame, exact timing
    seq_d = 32'd1;
    start_frame();
    feed(WORDS, 1'b0, 1'b1);
    finish_frame(1'b0, 1'b1);
    ack_frame();

    // Collision phase held after the last word
    in_collision_state = 1'b1;
    start_frame();
    feed(WORDS, 1'b0, 1'b0);
    finish_frame(1'b1, 1'b0);
    ack_frame();

    // Random valid gaps
    start_frame();
    feed(WORDS, 1'b1, 1'b0);
    finish_frame(1'b0, 1'b0);
    ack_frame();

    // Abort after 40 words, then a full reload
    start_frame();
    feed(40, 1'b0, 1'b0);
    s_valid = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    s_valid = 1'b0;
    chk("abort_sready", s_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", frame_count, exp_count);
    chk("abort_wvalid", asm_word_valid, 1'b0);
    chk("abort_sb_empty", exp_q.size(), 0);
    step();
    start_frame();
    feed(WORDS, 1'b0, 1'b0);
    finish_frame(1'b0, 1'b0);
    ack_frame();

    // Stall during load
    start_frame();
    feed(10, 1'b0, 1'b0);
    s_valid = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    repeat (15) step();
    chk("to_pre_busy", busy, 1'b1);
    chk("to_pre_err", err_timeout, 1'b0);
    step();
    chk("to_err", err_timeout, 1'b1);
    chk("to_idle", busy, 1'b0);
    chk("to_sready", s_ready, 1'b0);
    step();
    start_frame();
    chk("to_err_cleared", err_timeout, 1'b0);
`else
    repeat (40) step();
    chk("stall_busy", busy, 1'b1);
    chk("stall_sready", s_ready, 1'b1);
    chk("stall_err", err_timeout, 1'b0);
`endif
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("stall_abort_busy", busy, 1'b0);

    // Reset in PRESENT
    start_frame();
    feed(WORDS, 1'b0, 1'b0);
    finish_frame(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fr", frame_ready, 1'b0);
    chk("arst_count", frame_count, 16'd0);
    chk("arst_busy", busy, 1'b0);
    exp_count = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_fr", frame_ready, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    start_frame();
    feed(WORDS, 1'b0, 1'b0);
    finish_frame(1'b0, 1'b0);
    ack_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
